// File: rtl/mul_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// mul_cmd_sequencer
//
// Consumes the MUL controller's two command streams and drives the single
// memory-array port:
//   * external load/store commands (one-cycle strobe, always accepted)
//   * handshaked compute commands (NOP / ADD / MUL), each expanded into a
//     row-level micro-op sequence: read A, read B, write result.
// Load/store always owns the array port in its cycle; any pending micro-op
// holds its state and counters for that cycle.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   ExLdSt_valid      load/store strobe (no ready)
//   ExLdSt_command    [6]=dir (1=store, 0=load), [5:0]=row
//   ExLdSt_wdata      store data, sampled with ExLdSt_valid
//   ExLdSt_rdata      load return data (0 unless ExLdSt_rvalid)
//   ExLdSt_rvalid     one-cycle pulse, the cycle after a load
//   Compute_valid     compute command offered
//   Compute_ready     high only while idle
//   Compute_command   [24:21]=op [20:18]=wcode [17:12]=A [11:6]=B [5:0]=D
//   cmd_done          one-cycle pulse when a compute command retires
//   cmd_err           pulses with cmd_done for an illegal opcode
//   arr_en/arr_we     array access strobe / write select
//   arr_op            opcode of the active micro-op (0 for load/store)
//   arr_row           row address
//   arr_wdata         store data on a store, 0 otherwise
//   arr_rdata         array read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module mul_cmd_sequencer #(
    parameter int unsigned ROW_NUM = 64,
    parameter int unsigned ADDR_W  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ExLdSt_valid,
    input  logic [6:0]         ExLdSt_command,
    input  logic [ROW_NUM-1:0] ExLdSt_wdata,
    output logic [ROW_NUM-1:0] ExLdSt_rdata,
    output logic               ExLdSt_rvalid,
    input  logic               Compute_valid,
    output logic               Compute_ready,
    input  logic [24:0]        Compute_command,
    output logic               cmd_done,
    output logic               cmd_err,
    output logic               arr_en,
    output logic               arr_we,
    output logic [3:0]         arr_op,
    output logic [ADDR_W-1:0]  arr_row,
    output logic [ROW_NUM-1:0] arr_wdata,
    input  logic [ROW_NUM-1:0] arr_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;

    state_t state, state_nxt;

    // Latched command fields
    logic [3:0]        op_q;
    logic [2:0]        wc_q;
    logic [ADDR_W-1:0] a_q, b_q, d_q;
    logic              err_q;

    // Step counters: j = inner (ADD step / MUL inner), i = MUL outer
    logic [2:0]        i_q, j_q;

    logic              rvalid_q;

    // Command field decode
    logic [3:0]        cmd_op;
    logic              cmd_is_seq;
    logic              cmd_illegal;

    logic              ls_valid;
    logic              ls_dir;
    logic              accept;
    logic              stall;
    logic              is_mul;
    logic              last_i, last_j, seq_last;

    logic [ADDR_W-1:0] row_a, row_b, row_d;

    // Load/store is masked while reset is asserted so every output reads 0
    // immediately, even if a strobe happens to be present.
    assign ls_valid    = ExLdSt_valid & rst_n;
    assign ls_dir      = ExLdSt_command[6];

    assign cmd_op      = Compute_command[24:21];
    assign cmd_is_seq  = (cmd_op == OP_ADD) || (cmd_op == OP_MUL);
    assign cmd_illegal = !cmd_is_seq && (cmd_op != OP_NOP);

    assign accept      = Compute_valid && (state == S_IDLE);
    assign stall       = ls_valid;

    assign is_mul      = (op_q == OP_MUL);
    assign last_i      = (i_q == wc_q);
    assign last_j      = (j_q == wc_q);
    assign seq_last    = is_mul ? (last_i && last_j) : last_j;

    // Row addresses, wrapping modulo 2^ADDR_W. For ADD the outer counter
    // stays 0, so D+i+j reduces to D+j and one adder chain serves both ops.
    assign row_a = a_q + ADDR_W'(j_q);
    assign row_b = b_q + (is_mul ? ADDR_W'(i_q) : ADDR_W'(j_q));
    assign row_d = d_q + ADDR_W'(i_q) + ADDR_W'(j_q);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = cmd_is_seq ? S_RD_A : S_DONE;
                end
            end
            S_RD_A: begin
                if (!stall) state_nxt = S_RD_B;
            end
            S_RD_B: begin
                if (!stall) state_nxt = S_WR;
            end
            S_WR: begin
                if (!stall) state_nxt = seq_last ? S_DONE : S_RD_A;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Command latch and step counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            wc_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            d_q   <= '0;
            err_q <= 1'b0;
            i_q   <= '0;
            j_q   <= '0;
        end else if (accept) begin
            op_q  <= cmd_op;
            wc_q  <= Compute_command[20:18];
            a_q   <= ADDR_W'(Compute_command[17:12]);
            b_q   <= ADDR_W'(Compute_command[11:6]);
            d_q   <= ADDR_W'(Compute_command[5:0]);
            err_q <= cmd_illegal;
            i_q   <= '0;
            j_q   <= '0;
        end else if ((state == S_WR) && !stall) begin
            // Counters advance only after a completed write. On the final
            // step they may wrap; they are cleared again at the next accept.
            if (is_mul && last_j) begin
                j_q <= '0;
                i_q <= i_q + 3'd1;
            end else begin
                j_q <= j_q + 3'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Load return: rvalid follows a load by one cycle
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= ls_valid && !ls_dir;
        end
    end

    assign ExLdSt_rvalid = rvalid_q;
    assign ExLdSt_rdata  = rvalid_q ? arr_rdata : '0;

    // -----------------------------------------------------------------------
    // Output logic: array port mux and command status
    // -----------------------------------------------------------------------
    always_comb begin
        Compute_ready = (state == S_IDLE);
        cmd_done      = (state == S_DONE);
        cmd_err       = (state == S_DONE) && err_q;

        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_op    = '0;
        arr_row   = '0;
        arr_wdata = '0;

        if (ls_valid) begin
            // Load/store owns the port; the sequencer is stalled this cycle.
            arr_en    = 1'b1;
            arr_we    = ls_dir;
            arr_row   = ADDR_W'(ExLdSt_command[5:0]);
            arr_wdata = ls_dir ? ExLdSt_wdata : '0;
        end else begin
            case (state)
                S_RD_A: begin
                    arr_en  = 1'b1;
                    arr_op  = op_q;
                    arr_row = row_a;
                end
                S_RD_B: begin
                    arr_en  = 1'b1;
                    arr_op  = op_q;
                    arr_row = row_b;
                end
                S_WR: begin
                    arr_en  = 1'b1;
                    arr_we  = 1'b1;
                    arr_op  = op_q;
                    arr_row = row_d;
                end
                default: begin
                    arr_en = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_cmd_sequencer.sv
module tb_mul_cmd_sequencer;

    localparam int unsigned ROW_NUM = 64;
    localparam int unsigned ADDR_W  = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ExLdSt_valid = 1'b0;
    logic [6:0]         ExLdSt_command = '0;
    logic [ROW_NUM-1:0] ExLdSt_wdata = '0;
    logic [ROW_NUM-1:0] ExLdSt_rdata;
    logic               ExLdSt_rvalid;
    logic               Compute_valid = 1'b0;
    logic               Compute_ready;
    logic [24:0]        Compute_command = '0;
    logic               cmd_done;
    logic               cmd_err;
    logic               arr_en;
    logic               arr_we;
    logic [3:0]         arr_op;
    logic [ADDR_W-1:0]  arr_row;
    logic [ROW_NUM-1:0] arr_wdata;
    logic [ROW_NUM-1:0] arr_rdata = '0;

    mul_cmd_sequencer #(
        .ROW_NUM(ROW_NUM),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ExLdSt_valid   (ExLdSt_valid),
        .ExLdSt_command (ExLdSt_command),
        .ExLdSt_wdata   (ExLdSt_wdata),
        .ExLdSt_rdata   (ExLdSt_rdata),
        .ExLdSt_rvalid  (ExLdSt_rvalid),
        .Compute_valid  (Compute_valid),
        .Compute_ready  (Compute_ready),
        .Compute_command(Compute_command),
        .cmd_done       (cmd_done),
        .cmd_err        (cmd_err),
        .arr_en         (arr_en),
        .arr_we         (arr_we),
        .arr_op         (arr_op),
        .arr_row        (arr_row),
        .arr_wdata      (arr_wdata),
        .arr_rdata      (arr_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory array behind the port
    logic [63:0] mem [64] = '{default: '0};
    always @(posedge clk) begin
        if (arr_en && arr_we)  mem[arr_row] <= arr_wdata;
        if (arr_en && !arr_we) arr_rdata    <= mem[arr_row];
    end

    // Reference contents for rows written by external stores
    logic [63:0] ref_mem [64] = '{default: '0};

    typedef struct packed {
        logic [10:0] key;   // {we, op, row}
        logic [63:0] wd;
    } acc_t;

    acc_t        cq[$];     // expected micro-op accesses
    acc_t        lq[$];     // expected load/store accesses
    logic [63:0] rq[$];     // expected load return data
    logic [63:0] dq[$];     // expected {done cycle, cmd_err}

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampling away from the rising edge
    always @(negedge clk) begin
        acc_t        e;
        logic [63:0] v;
        if (arr_en === 1'b1) begin
            if (arr_op == 4'd0) begin
                if (lq.size() > 0) begin
                    e = lq.pop_front();
                    chk("ls_port", 64'({arr_we, arr_op, arr_row}), 64'(e.key));
                    chk("ls_wdata", arr_wdata, e.wd);
                end else begin
                    chk("ls_extra", 64'(arr_en), 64'd0);
                end
            end else begin
                if (cq.size() > 0) begin
                    e = cq.pop_front();
                    chk("uop_port", 64'({arr_we, arr_op, arr_row}), 64'(e.key));
                    chk("uop_wdata", arr_wdata, e.wd);
                end else begin
                    chk("uop_extra", 64'(arr_en), 64'd0);
                end
            end
        end
        if (ExLdSt_rvalid === 1'b1) begin
            if (rq.size() > 0) begin
                v = rq.pop_front();
                chk("ld_rdata", ExLdSt_rdata, v);
            end else begin
                chk("rvalid_extra", 64'(ExLdSt_rvalid), 64'd0);
            end
        end
        if (cmd_done === 1'b1) begin
            if (dq.size() > 0) begin
                v = dq.pop_front();
                chk("done_cyc_err", 64'({cyc, cmd_err}), v);
            end else begin
                chk("done_extra", 64'(cmd_done), 64'd0);
            end
        end
    end

    // Drive a load/store strobe for the current cycle and record expectations
    task automatic ldst_drive(input logic dir, input logic [5:0] row, input logic [63:0] data);
        ExLdSt_valid   = 1'b1;
        ExLdSt_command = {dir, row};
        ExLdSt_wdata   = data;
        lq.push_back(acc_t'{{dir, 4'h0, row}, dir ? data : 64'h0});
        if (dir) ref_mem[row] = data;
        else     rq.push_back(ref_mem[row]);
    endtask

    task automatic ldst(input logic dir, input logic [5:0] row, input logic [63:0] data);
        ldst_drive(dir, row, data);
        @(posedge clk); #1;
        ExLdSt_valid = 1'b0;
        ExLdSt_wdata = '0;
    endtask

    // Offer a compute command; extra = number of stall cycles the caller adds
    task automatic run_cmd(input logic [3:0] op, input logic [2:0] wc,
                           input logic [5:0] a, input logic [5:0] b,
                           input logic [5:0] d, input int unsigned extra);
        int unsigned n;
        int unsigned lat;
        int unsigned k;
        logic [5:0]  ra, rb, rd;
        logic        err;
        n = int'(wc) + 1;
        k = 0;
        while (!Compute_ready && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait", 64'(Compute_ready), 64'd1);
        err = !(op inside {4'd0, 4'd1, 4'd2});
        if (op == 4'd1) begin
            for (int j = 0; j < int'(n); j++) begin
                ra = a + 6'(j); rb = b + 6'(j); rd = d + 6'(j);
                cq.push_back(acc_t'{{1'b0, op, ra}, 64'h0});
                cq.push_back(acc_t'{{1'b0, op, rb}, 64'h0});
                cq.push_back(acc_t'{{1'b1, op, rd}, 64'h0});
            end
            lat = 3 * n + 1;
        end else if (op == 4'd2) begin
            for (int i = 0; i < int'(n); i++) begin
                for (int j = 0; j < int'(n); j++) begin
                    ra = a + 6'(j); rb = b + 6'(i); rd = d + 6'(i) + 6'(j);
                    cq.push_back(acc_t'{{1'b0, op, ra}, 64'h0});
                    cq.push_back(acc_t'{{1'b0, op, rb}, 64'h0});
                    cq.push_back(acc_t'{{1'b1, op, rd}, 64'h0});
                end
            end
            lat = 3 * n * n + 1;
        end else begin
            lat = 1;
        end
        dq.push_back(64'({cyc + lat + extra, err}));
        Compute_command = {op, wc, a, b, d};
        Compute_valid   = 1'b1;
        @(posedge clk); #1;
        Compute_valid   = 1'b0;
    endtask

    task automatic wait_done();
        int unsigned k;
        k = 0;
        while (dq.size() != 0 && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_timeout", 64'(dq.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  64'(Compute_ready), 64'd1);
        chk("rst_arr_en", 64'(arr_en),        64'd0);
        chk("rst_done",   64'(cmd_done),      64'd0);
        chk("rst_err",    64'(cmd_err),       64'd0);
        chk("rst_rvalid", 64'(ExLdSt_rvalid), 64'd0);
        chk("rst_rdata",  ExLdSt_rdata,       64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Store then load row 5, plus a second stored row
        ldst(1'b1, 6'd5, 64'hDEADBEEF);
        ldst(1'b0, 6'd5, 64'h0);
        ldst(1'b1, 6'd7, 64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;

        // ADD with row wrap
        run_cmd(4'd1, 3'd2, 6'd10, 6'd20, 6'd62, 0);
        wait_done();

        // MUL N=2
        run_cmd(4'd2, 3'd1, 6'd0, 6'd8, 6'd16, 0);
        wait_done();

        // ADD N=1 with a load landing on the RD_B cycle
        run_cmd(4'd1, 3'd0, 6'd30, 6'd31, 6'd32, 1);
        @(posedge clk); #1;
        ldst(1'b0, 6'd7, 64'h0);
        wait_done();

        // Illegal opcode, then NOP
        run_cmd(4'hF, 3'd3, 6'd1, 6'd2, 6'd3, 0);
        wait_done();
        run_cmd(4'd0, 3'd5, 6'd1, 6'd2, 6'd3, 0);
        wait_done();

        // Store in the same cycle as acceptance: no stall, both proceed
        ldst_drive(1'b1, 6'd9, 64'hCAFE_F00D);
        run_cmd(4'd1, 3'd0, 6'd1, 6'd2, 6'd3, 0);
        ExLdSt_valid = 1'b0;
        ExLdSt_wdata = '0;
        wait_done();
        ldst(1'b0, 6'd9, 64'h0);
        @(posedge clk); #1;

        // Reset in the middle of a long MUL, with a load return pending
        run_cmd(4'd2, 3'd7, 6'd0, 6'd8, 6'd48, 0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        ldst_drive(1'b0, 6'd5, 64'h0);
        @(posedge clk); #1;
        ExLdSt_valid = 1'b0;
        rst_n = 1'b0;
        cq.delete();
        dq.delete();
        rq.delete();
        #1;
        chk("mid_rst_arr_en", 64'(arr_en),        64'd0);
        chk("mid_rst_ready",  64'(Compute_ready), 64'd1);
        chk("mid_rst_done",   64'(cmd_done),      64'd0);
        chk("mid_rst_rvalid", 64'(ExLdSt_rvalid), 64'd0);
        chk("mid_rst_rdata",  ExLdSt_rdata,       64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Sequencer usable again after reset
        run_cmd(4'd1, 3'd1, 6'd40, 6'd41, 6'd42, 0);
        wait_done();
        repeat (2) begin
            @(posedge clk); #1;
        end

        chk("uop_left", 64'(cq.size()), 64'd0);
        chk("ls_left",  64'(lq.size()), 64'd0);
        chk("ld_left",  64'(rq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
